// File: rtl/shreg_seq_ctrl.sv
// Command sequencer for a 4-bit universal shift register: takes one load/shift/rotate op per
// handshake, drives MODO/ENB/DIR/S_IN/D for the exact cycle count, and returns Q and S_OUT samples.
module shreg_seq_ctrl #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 4
) (
   input  logic                    CLK,
   input  logic                    RESET_L,
   input  logic                    CMD_VALID,
   output logic                    CMD_READY,
   input  logic [1:0]              CMD_OP,
   input  logic                    CMD_DIR,
   input  logic [CNT_W-1:0]        CMD_CNT,
   input  logic [WIDTH-1:0]        CMD_DATA,
   input  logic                    CMD_SIN,
   output logic                    ENB,
   output logic                    DIR,
   output logic [1:0]              MODO,
   output logic [WIDTH-1:0]        D,
   output logic                    S_IN,
   input  logic [WIDTH-1:0]        Q,
   input  logic                    S_OUT,
   output logic                    RSP_VALID,
   input  logic                    RSP_READY,
   output logic [WIDTH-1:0]        RSP_Q,
   output logic [(2**CNT_W)-2:0]   RSP_SBITS,
   output logic                    BUSY
);

   localparam int SB_W = (2**CNT_W) - 1;

   localparam logic [1:0] OP_SHIFT   = 2'b00;
   localparam logic [1:0] OP_ROTATE  = 2'b01;
   localparam logic [1:0] OP_LOAD    = 2'b10;
   localparam logic [1:0] OP_LOAD_SO = 2'b11;

   localparam logic [1:0] MODO_SHIFT  = 2'b00;
   localparam logic [1:0] MODO_ROTATE = 2'b01;
   localparam logic [1:0] MODO_LOAD   = 2'b10;
   localparam logic [1:0] MODO_HOLD   = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SHIFT,
      S_SETTLE,
      S_RESP
   } state_t;

   state_t             state_q;
   state_t             state_d;

   logic [1:0]         op_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               dir_q;
   logic [WIDTH-1:0]   data_q;
   logic               sin_q;
   logic               rsp_valid_q;
   logic [WIDTH-1:0]   rsp_q_q;
   logic [SB_W-1:0]    sbits_q;

   logic               accept;
   logic               shift_edge;
   logic               settle_edge;
   logic               rsp_done;

   // Shift-class modes: only op 01 rotates, ops 00 and 11 shift.
   function automatic logic [1:0] shift_modo(input logic [1:0] op);
      return (op == OP_ROTATE) ? MODO_ROTATE : MODO_SHIFT;
   endfunction

   // Load+shift-out always feeds zeros behind the data leaving the register.
   function automatic logic shift_sin(input logic [1:0] op, input logic sin);
      return (op == OP_LOAD_SO) ? 1'b0 : sin;
   endfunction

   always_comb begin
      state_d     = state_q;
      ENB         = 1'b0;
      MODO        = MODO_HOLD;
      D           = '0;
      S_IN        = 1'b0;
      accept      = 1'b0;
      shift_edge  = 1'b0;
      settle_edge = 1'b0;
      rsp_done    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (CMD_VALID) begin
               accept = 1'b1;
               if (CMD_OP[1])
                  state_d = S_LOAD;
               else if (CMD_CNT != '0)
                  state_d = S_SHIFT;
               else
                  state_d = S_SETTLE;
            end
         end
         S_LOAD: begin
            ENB  = 1'b1;
            MODO = MODO_LOAD;
            D    = data_q;
            if (op_q == OP_LOAD_SO && cnt_q != '0)
               state_d = S_SHIFT;
            else
               state_d = S_SETTLE;
         end
         S_SHIFT: begin
            ENB        = 1'b1;
            MODO       = shift_modo(op_q);
            S_IN       = shift_sin(op_q, sin_q);
            shift_edge = 1'b1;
            if (cnt_q == CNT_W'(1))
               state_d = S_SETTLE;
         end
         S_SETTLE: begin
            settle_edge = 1'b1;
            state_d     = S_RESP;
         end
         S_RESP: begin
            if (rsp_valid_q && RSP_READY) begin
               rsp_done = 1'b1;
               state_d  = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RESET_L) begin
         state_q     <= S_IDLE;
         op_q        <= OP_SHIFT;
         cnt_q       <= '0;
         dir_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_q_q     <= '0;
         sbits_q     <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op_q    <= CMD_OP;
            cnt_q   <= CMD_CNT;
            sbits_q <= '0;
            // DIR only moves when the op will really shift, so idle DIR is the last one used.
            if (CMD_OP != OP_LOAD && CMD_CNT != '0)
               dir_q <= CMD_DIR;
         end
         if (shift_edge) begin
            cnt_q   <= cnt_q - CNT_W'(1);
            sbits_q <= (sbits_q << 1) | SB_W'(S_OUT);
         end
         if (settle_edge) begin
            rsp_q_q     <= Q;
            rsp_valid_q <= 1'b1;
         end
         if (rsp_done)
            rsp_valid_q <= 1'b0;
      end
   end

   // Payload fields are only consumed after an accept, so they carry no reset.
   always_ff @(posedge CLK) begin
      if (accept) begin
         data_q <= CMD_DATA;
         sin_q  <= CMD_SIN;
      end
   end

   assign CMD_READY = (state_q == S_IDLE);
   assign BUSY      = (state_q != S_IDLE);
   assign DIR       = dir_q;
   assign RSP_VALID = rsp_valid_q;
   assign RSP_Q     = rsp_q_q;
   assign RSP_SBITS = sbits_q;

endmodule

// File: tb/tb_shreg_seq_ctrl.sv
// Bench for shreg_seq_ctrl: models the 4-bit register it drives, predicts each op's outcome
// from the op rules, and checks every cycle's outputs plus directed literal cases.
module tb_shreg_seq_ctrl;

   logic        clk;
   logic        RESET_L;
   logic        CMD_VALID;
   logic        CMD_READY;
   logic [1:0]  CMD_OP;
   logic        CMD_DIR;
   logic [3:0]  CMD_CNT;
   logic [3:0]  CMD_DATA;
   logic        CMD_SIN;
   logic        ENB;
   logic        DIR;
   logic [1:0]  MODO;
   logic [3:0]  D;
   logic        S_IN;
   logic [3:0]  Q;
   logic        S_OUT;
   logic        RSP_VALID;
   logic        RSP_READY;
   logic [3:0]  RSP_Q;
   logic [14:0] RSP_SBITS;
   logic        BUSY;

   int n_checks = 0;
   int n_fail   = 0;
   int rdy_mode = 1;   // 0 random, 1 forced low, 2 forced high

   shreg_seq_ctrl #(.WIDTH(4), .CNT_W(4)) dut (
      .CLK(clk), .RESET_L(RESET_L), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
      .CMD_OP(CMD_OP), .CMD_DIR(CMD_DIR), .CMD_CNT(CMD_CNT), .CMD_DATA(CMD_DATA),
      .CMD_SIN(CMD_SIN), .ENB(ENB), .DIR(DIR), .MODO(MODO), .D(D), .S_IN(S_IN),
      .Q(Q), .S_OUT(S_OUT), .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
      .RSP_Q(RSP_Q), .RSP_SBITS(RSP_SBITS), .BUSY(BUSY)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // The universal shift register the controller drives.
   logic [3:0] reg_q = 4'b0000;
   assign Q     = reg_q;
   assign S_OUT = DIR ? reg_q[0] : reg_q[3];
   always @(posedge clk) begin
      if (ENB === 1'b1) begin
         case (MODO)
            2'b00: reg_q <= DIR ? {S_IN, reg_q[3:1]} : {reg_q[2:0], S_IN};
            2'b01: reg_q <= DIR ? {reg_q[0], reg_q[3:1]} : {reg_q[2:0], reg_q[3]};
            2'b10: reg_q <= D;
            default: reg_q <= reg_q;
         endcase
      end
   end

   always @(posedge clk) begin
      #1;
      if (rdy_mode == 2)      RSP_READY = 1'b1;
      else if (rdy_mode == 1) RSP_READY = 1'b0;
      else                    RSP_READY = 1'($urandom_range(0, 1));
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit         m_init     = 0;
   bit         m_busy     = 0;
   int         m_k, m_L, m_S;
   logic [1:0] m_op;
   bit         m_dir, m_sin;
   int         m_data;
   int         m_exp_q, m_exp_sb;
   int         m_rsp_q    = 0;
   int         m_rsp_sb   = 0;
   bit         m_dir_hold = 0;

   task automatic model_accept();
      int q, sb, in, so;
      m_op   = CMD_OP;
      m_dir  = CMD_DIR;
      m_sin  = CMD_SIN;
      m_data = int'(CMD_DATA);
      m_L    = (CMD_OP[1]) ? 1 : 0;
      m_S    = (CMD_OP == 2'b10) ? 0 : int'(CMD_CNT);
      q      = m_L ? m_data : int'(reg_q);
      sb     = 0;
      for (int i = 0; i < m_S; i++) begin
         so = m_dir ? (q & 1) : ((q >> 3) & 1);
         sb = (sb << 1) | so;
         if (m_op == 2'b01) in = so;
         else if (m_op == 2'b11) in = 0;
         else in = m_sin;
         q = m_dir ? ((q >> 1) | (in << 3)) : (((q << 1) | in) & 15);
      end
      m_exp_q  = q;
      m_exp_sb = sb;
      if (m_S > 0) m_dir_hold = m_dir;
      m_k    = 1;
      m_busy = 1;
   endtask

   task automatic check_cycle();
      if (!m_busy) begin
         chk("idle ENB", ENB, 0);
         chk("idle MODO", MODO, 3);
         chk("idle D", D, 0);
         chk("idle S_IN", S_IN, 0);
         chk("idle DIR", DIR, m_dir_hold);
         chk("idle CMD_READY", CMD_READY, 1);
         chk("idle BUSY", BUSY, 0);
         chk("idle RSP_VALID", RSP_VALID, 0);
         chk("idle RSP_Q", RSP_Q, m_rsp_q);
         chk("idle RSP_SBITS", RSP_SBITS, m_rsp_sb);
      end else begin
         if (m_k <= m_L) begin
            chk("load ENB", ENB, 1);
            chk("load MODO", MODO, 2);
            chk("load D", D, m_data);
            chk("load S_IN", S_IN, 0);
         end else if (m_k <= m_L + m_S) begin
            chk("shift ENB", ENB, 1);
            chk("shift MODO", MODO, (m_op == 2'b01) ? 1 : 0);
            chk("shift DIR", DIR, m_dir);
            chk("shift S_IN", S_IN, (m_op == 2'b11) ? 0 : m_sin);
            chk("shift D", D, 0);
         end else begin
            chk("wait ENB", ENB, 0);
            chk("wait MODO", MODO, 3);
            chk("wait D", D, 0);
            chk("wait S_IN", S_IN, 0);
            chk("wait DIR", DIR, m_dir_hold);
            chk("rsp RSP_SBITS", RSP_SBITS, m_exp_sb);
         end
         chk("busy RSP_VALID", RSP_VALID, (m_k >= m_L + m_S + 2) ? 1 : 0);
         chk("busy CMD_READY", CMD_READY, 0);
         chk("busy BUSY", BUSY, 1);
         chk("busy RSP_Q", RSP_Q, m_rsp_q);
      end
   endtask

   // Compare against the model, then advance it using the inputs held for the coming edge.
   always @(negedge clk) begin
      if (m_init) check_cycle();
      if (RESET_L !== 1'b1) begin
         m_busy = 0; m_rsp_q = 0; m_rsp_sb = 0; m_dir_hold = 0; m_init = 1;
      end else if (m_init) begin
         if (!m_busy) begin
            if (CMD_VALID) model_accept();
         end else begin
            if (m_k == m_L + m_S + 1) m_rsp_q = m_exp_q;
            if (m_k >= m_L + m_S + 2 && RSP_READY) begin
               m_busy   = 0;
               m_rsp_sb = m_exp_sb;
            end else begin
               m_k++;
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic garbage_cmd();
      CMD_OP   = 2'($urandom_range(0, 3));
      CMD_DIR  = 1'($urandom_range(0, 1));
      CMD_CNT  = 4'($urandom_range(0, 15));
      CMD_DATA = 4'($urandom_range(0, 15));
      CMD_SIN  = 1'($urandom_range(0, 1));
   endtask

   task automatic send(input logic [1:0] op, input logic dir, input logic [3:0] cnt,
                       input logic [3:0] data, input logic sin);
      bit ok;
      step();
      CMD_OP = op; CMD_DIR = dir; CMD_CNT = cnt; CMD_DATA = data; CMD_SIN = sin;
      CMD_VALID = 1'b1;
      ok = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (CMD_READY === 1'b1) begin ok = 1; break; end
      end
      @(posedge clk);
      #1;
      CMD_VALID = 1'b0;
      garbage_cmd();
      chk("cmd accepted", 32'(ok), 1);
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (CMD_READY === 1'b1) begin ok = 1; break; end
      end
      chk("return to idle", 32'(ok), 1);
   endtask

   task automatic lit_op(input string nm, input logic [1:0] op, input logic dir,
                         input logic [3:0] cnt, input logic [3:0] data, input logic sin,
                         input logic [3:0] eq, input logic [14:0] esb, input int nb,
                         input int elat, input int eenb, input int hold);
      int k, enb;
      logic [14:0] mask;
      rdy_mode = 1;
      send(op, dir, cnt, data, sin);
      k = 0; enb = 0;
      while (k < 40) begin
         @(negedge clk);
         k++;
         if (ENB === 1'b1) enb++;
         if (RSP_VALID === 1'b1) break;
      end
      mask = (15'(1) << nb) - 15'(1);
      chk({nm, " latency"}, 32'(k - 1), 32'(elat));
      chk({nm, " ENB cycles"}, 32'(enb), 32'(eenb));
      chk({nm, " RSP_Q"}, RSP_Q, eq);
      chk({nm, " RSP_SBITS"}, RSP_SBITS & mask, esb);
      for (int h = 0; h < hold; h++) begin
         step();
         CMD_VALID = 1'b1;
         garbage_cmd();
         @(negedge clk);
         chk({nm, " held RSP_VALID"}, RSP_VALID, 1);
         chk({nm, " held RSP_Q"}, RSP_Q, eq);
         chk({nm, " held CMD_READY"}, CMD_READY, 0);
      end
      if (hold > 0) begin
         step();
         CMD_VALID = 1'b0;
      end
      rdy_mode = 2;
      wait_idle();
      rdy_mode = 0;
   endtask

   initial begin
      RESET_L = 1'b0; CMD_VALID = 1'b0; RSP_READY = 1'b0;
      CMD_OP = 2'b00; CMD_DIR = 1'b0; CMD_CNT = 4'd0; CMD_DATA = 4'd0; CMD_SIN = 1'b0;
      repeat (3) step();
      RESET_L = 1'b1;
      @(negedge clk);
      chk("reset ENB", ENB, 0);
      chk("reset MODO", MODO, 3);
      chk("reset CMD_READY", CMD_READY, 1);
      chk("reset BUSY", BUSY, 0);
      chk("reset RSP_VALID", RSP_VALID, 0);
      chk("reset RSP_Q", RSP_Q, 0);
      chk("reset RSP_SBITS", RSP_SBITS, 0);
      chk("reset DIR", DIR, 0);
      chk("reset D", D, 0);

      lit_op("load 1011", 2'b10, 1'b0, 4'd5, 4'b1011, 1'b1, 4'b1011, 15'b0, 0, 2, 1, 3);
      lit_op("load 1001", 2'b10, 1'b0, 4'd0, 4'b1001, 1'b0, 4'b1001, 15'b0, 0, 2, 1, 0);
      lit_op("shl2 sin1", 2'b00, 1'b0, 4'd2, 4'b0000, 1'b1, 4'b0111, 15'b10, 2, 3, 2, 0);
      lit_op("load 0110", 2'b10, 1'b1, 4'd3, 4'b0110, 1'b0, 4'b0110, 15'b0, 0, 2, 1, 0);
      lit_op("ror5", 2'b01, 1'b1, 4'd5, 4'b1111, 1'b0, 4'b0011, 15'b01100, 5, 6, 5, 0);
      lit_op("rot cnt0", 2'b01, 1'b0, 4'd0, 4'b1111, 1'b1, 4'b0011, 15'b0, 0, 1, 0, 0);
      lit_op("loadso 1100", 2'b11, 1'b0, 4'd4, 4'b1100, 1'b1, 4'b0000, 15'b1100, 4, 6, 5, 0);

      // Reset in the middle of a long shift.
      rdy_mode = 1;
      send(2'b00, 1'b1, 4'd10, 4'd0, 1'b1);
      step();
      RESET_L = 1'b0;
      step();
      step();
      RESET_L = 1'b1;
      @(negedge clk);
      chk("midreset ENB", ENB, 0);
      chk("midreset MODO", MODO, 3);
      chk("midreset RSP_VALID", RSP_VALID, 0);
      chk("midreset CMD_READY", CMD_READY, 1);
      rdy_mode = 0;

      for (int n = 0; n < 200; n++) begin
         logic [3:0] c;
         c = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
         send(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), c,
              4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
         repeat ($urandom_range(0, 2)) step();
      end
      wait_idle();
      repeat (2) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1, "watchdog expired");
   end

endmodule
